// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, bus widths and opcode-format helpers.
package cpu_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned INST_W = 16;
  localparam int unsigned LEN_W  = 2;

  // Opcode-byte bit that marks a 2-byte (one-argument) instruction.
  localparam int unsigned OPC_ONE_ARG_BIT = 7;

  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    FETCH_HI,
    FETCH_LO,
    HOLD
  } fetch_state_t;

  function automatic logic is_two_byte(input logic [DATA_W-1:0] opc);
    return opc[OPC_ONE_ARG_BIT];
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: byte memory bus, instruction handshake to the decoder and PC redirect.
interface fetch_unit_if;
  import cpu_pkg::*;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic [INST_W-1:0] inst;
  logic              inst_valid;
  logic              inst_ready;
  logic [ADDR_W-1:0] inst_pc;
  logic [LEN_W-1:0]  inst_len;
  logic [ADDR_W-1:0] next_pc;

  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;

  modport master (
    output mem_req, mem_addr,
    input  mem_ack, mem_rdata,
    output inst, inst_valid, inst_pc, inst_len, next_pc,
    input  inst_ready,
    input  redirect, redirect_pc
  );

  modport slave (
    input  mem_req, mem_addr,
    output mem_ack, mem_rdata,
    input  inst, inst_valid, inst_pc, inst_len, next_pc,
    output inst_ready,
    output redirect, redirect_pc
  );

endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: reads 1 or 2 bytes per instruction, presents a 16-bit word
// with valid/ready, and restarts at a new PC on redirect. One instruction in flight.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic          clk,
  input  logic          rst,
  fetch_unit_if.master  bus
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              mem_req_q, mem_req_d;
  logic [INST_W-1:0] inst_q, inst_d;
  logic              inst_valid_q, inst_valid_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [LEN_W-1:0]  inst_len_q, inst_len_d;
  logic [ADDR_W-1:0] next_pc_q, next_pc_d;

  logic              ack;
  logic [ADDR_W-1:0] pc_inc;

  // Acks are honoured only against an outstanding request.
  assign ack    = mem_req_q && bus.mem_ack;
  assign pc_inc = pc_q + ADDR_W'(1);

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FETCH_HI;
      pc_q         <= RESET_PC;
      mem_req_q    <= 1'b0;
      inst_q       <= '0;
      inst_valid_q <= 1'b0;
      inst_pc_q    <= '0;
      inst_len_q   <= '0;
      next_pc_q    <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      mem_req_q    <= mem_req_d;
      inst_q       <= inst_d;
      inst_valid_q <= inst_valid_d;
      inst_pc_q    <= inst_pc_d;
      inst_len_q   <= inst_len_d;
      next_pc_q    <= next_pc_d;
    end
  end

  // Next-state and next-output logic; redirect overrides everything.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    mem_req_d    = mem_req_q;
    inst_d       = inst_q;
    inst_valid_d = inst_valid_q;
    inst_pc_d    = inst_pc_q;
    inst_len_d   = inst_len_q;
    next_pc_d    = next_pc_q;

    if (bus.redirect) begin
      pc_d         = bus.redirect_pc;
      state_d      = FETCH_HI;
      inst_valid_d = 1'b0;
      mem_req_d    = 1'b0;
    end else begin
      case (state_q)
        FETCH_HI: begin
          mem_req_d = 1'b1;
          if (ack) begin
            inst_d[INST_W-1:DATA_W] = bus.mem_rdata;
            inst_pc_d               = pc_q;
            pc_d                    = pc_inc;
            if (is_two_byte(bus.mem_rdata)) begin
              state_d = FETCH_LO;
            end else begin
              inst_d[DATA_W-1:0] = '0;
              inst_len_d         = LEN_W'(1);
              next_pc_d          = pc_inc;
              inst_valid_d       = 1'b1;
              mem_req_d          = 1'b0;
              state_d            = HOLD;
            end
          end
        end
        FETCH_LO: begin
          mem_req_d = 1'b1;
          if (ack) begin
            inst_d[DATA_W-1:0] = bus.mem_rdata;
            pc_d               = pc_inc;
            inst_len_d         = LEN_W'(2);
            next_pc_d          = pc_inc;
            inst_valid_d       = 1'b1;
            mem_req_d          = 1'b0;
            state_d            = HOLD;
          end
        end
        HOLD: begin
          mem_req_d    = 1'b0;
          inst_valid_d = 1'b1;
          if (bus.inst_ready) begin
            inst_valid_d = 1'b0;
            mem_req_d    = 1'b1;
            state_d      = FETCH_HI;
          end
        end
        default: begin
          state_d   = FETCH_HI;
          mem_req_d = 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = pc_q;
  assign bus.inst       = inst_q;
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.inst_len   = inst_len_q;
  assign bus.next_pc    = next_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: two instances (reset PC 0 and 16'hFFFF) sharing a byte memory image.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  always #5 clk = ~clk;

  fetch_unit_if bus ();
  fetch_unit_if bus2 ();

  fetch_unit u_dut (.clk(clk), .rst(rst), .bus(bus.master));
  fetch_unit #(.RESET_PC(16'hFFFF)) u_dut2 (.clk(clk), .rst(rst2), .bus(bus2.master));

  logic [7:0] mem [0:65535];

  int nvec = 0;
  int nerr = 0;

  // Memory for DUT 1: acks after a per-request delay.
  int unsigned wait_cnt = 0;
  int unsigned delay = 0;
  logic        rand_mode = 1'b0;

  always_comb begin
    bus.mem_ack   = bus.mem_req && (wait_cnt >= delay);
    bus.mem_rdata = mem[bus.mem_addr];
  end

  always @(posedge clk) begin
    if (bus.mem_req && !bus.mem_ack) begin
      wait_cnt <= wait_cnt + 1;
    end else begin
      wait_cnt <= 0;
      if (bus.mem_ack && rand_mode) delay <= $urandom_range(0, 7);
    end
  end

  // Address must not move while a request is pending.
  logic        prev_req = 1'b0;
  logic        prev_ack = 1'b0;
  logic [15:0] prev_addr = 16'h0;
  logic        addr_unstable = 1'b0;
  always @(posedge clk) begin
    if (prev_req && !prev_ack && bus.mem_req && bus.mem_addr != prev_addr)
      addr_unstable <= 1'b1;
    prev_req  <= bus.mem_req;
    prev_ack  <= bus.mem_ack;
    prev_addr <= bus.mem_addr;
  end

  // Memory for DUT 2: always acks immediately.
  always_comb begin
    bus2.mem_ack     = bus2.mem_req;
    bus2.mem_rdata   = mem[bus2.mem_addr];
    bus2.inst_ready  = 1'b0;
    bus2.redirect    = 1'b0;
    bus2.redirect_pc = 16'h0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [15:0] pc;
    logic [15:0] inst;
    logic [1:0]  len;
  } exp_t;

  exp_t stream [6];

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
    mem[0]     = 8'h01;
    mem[1]     = 8'h7F;
    mem[2]     = 8'h9A;
    mem[3]     = 8'hEE;
    mem[16'h40] = 8'h81;
    mem[16'h41] = 8'h23;
    // Stream for the random-delay phase, starting at 16'h0042.
    mem[16'h42] = 8'h05;
    mem[16'h43] = 8'h83; mem[16'h44] = 8'h11;
    mem[16'h45] = 8'h00;
    mem[16'h46] = 8'hFF; mem[16'h47] = 8'h22;
    mem[16'h48] = 8'h7E;
    mem[16'h49] = 8'h80; mem[16'h4A] = 8'h00;
    stream[0] = '{16'h0042, 16'h0500, 2'd1};
    stream[1] = '{16'h0043, 16'h8311, 2'd2};
    stream[2] = '{16'h0045, 16'h0000, 2'd1};
    stream[3] = '{16'h0046, 16'hFF22, 2'd2};
    stream[4] = '{16'h0048, 16'h7E00, 2'd1};
    stream[5] = '{16'h0049, 16'h8000, 2'd2};

    bus.inst_ready  = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0;

    // Reset values
    tick(); tick();
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_valid", 32'(bus.inst_valid), 32'd0);
    check("rst_inst", 32'(bus.inst), 32'h0);
    check("rst_len", 32'(bus.inst_len), 32'd0);
    check("rst_inst_pc", 32'(bus.inst_pc), 32'h0);
    check("rst_next_pc", 32'(bus.next_pc), 32'h0);

    // First 1-byte instruction: request one cycle, valid the next
    rst = 1'b0;
    tick();
    check("c1_mem_req", 32'(bus.mem_req), 32'd1);
    check("c1_mem_addr", 32'(bus.mem_addr), 32'h0);
    check("c1_valid", 32'(bus.inst_valid), 32'd0);
    tick();
    check("i0_valid", 32'(bus.inst_valid), 32'd1);
    check("i0_inst", 32'(bus.inst), 32'h0100);
    check("i0_len", 32'(bus.inst_len), 32'd1);
    check("i0_pc", 32'(bus.inst_pc), 32'h0);
    check("i0_next_pc", 32'(bus.next_pc), 32'h1);

    // Stall in HOLD for 5 cycles
    for (int i = 0; i < 5; i++) begin
      tick();
      check("hold_valid", 32'(bus.inst_valid), 32'd1);
      check("hold_inst", 32'(bus.inst), 32'h0100);
      check("hold_pc", 32'(bus.inst_pc), 32'h0);
      check("hold_mem_req", 32'(bus.mem_req), 32'd0);
    end

    // Accept, then back-to-back 1-byte at address 1
    bus.inst_ready = 1'b1;
    tick();
    bus.inst_ready = 1'b0;
    check("acc_valid", 32'(bus.inst_valid), 32'd0);
    check("acc_mem_req", 32'(bus.mem_req), 32'd1);
    check("acc_mem_addr", 32'(bus.mem_addr), 32'h1);
    tick();
    check("i1_inst", 32'(bus.inst), 32'h7F00);
    check("i1_pc", 32'(bus.inst_pc), 32'h1);
    check("i1_next_pc", 32'(bus.next_pc), 32'h2);

    // Reset mid-fetch, then a 2-byte instruction at 0 with ready tied high
    bus.inst_ready = 1'b1;
    tick();
    check("pre_rst_addr", 32'(bus.mem_addr), 32'h2);
    rst = 1'b1;
    mem[0] = 8'h88;
    mem[1] = 8'h05;
    tick();
    check("rst2_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst2_valid", 32'(bus.inst_valid), 32'd0);
    rst = 1'b0;
    tick();
    check("r_mem_addr", 32'(bus.mem_addr), 32'h0);
    tick();
    check("lo_mem_addr", 32'(bus.mem_addr), 32'h1);
    check("lo_mem_req", 32'(bus.mem_req), 32'd1);
    check("lo_valid", 32'(bus.inst_valid), 32'd0);
    tick();
    check("i2_valid", 32'(bus.inst_valid), 32'd1);
    check("i2_inst", 32'(bus.inst), 32'h8805);
    check("i2_len", 32'(bus.inst_len), 32'd2);
    check("i2_pc", 32'(bus.inst_pc), 32'h0);
    check("i2_next_pc", 32'(bus.next_pc), 32'h2);
    tick();
    check("nx_mem_addr", 32'(bus.mem_addr), 32'h2);
    check("nx_mem_req", 32'(bus.mem_req), 32'd1);
    check("nx_valid", 32'(bus.inst_valid), 32'd0);

    // Redirect while in FETCH_LO with an ack in the same cycle
    bus.inst_ready = 1'b0;
    tick();
    check("rd_pre_addr", 32'(bus.mem_addr), 32'h3);
    check("rd_pre_ack", 32'(bus.mem_ack), 32'd1);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0040;
    tick();
    bus.redirect = 1'b0;
    check("rd_mem_req", 32'(bus.mem_req), 32'd0);
    check("rd_mem_addr", 32'(bus.mem_addr), 32'h0040);
    check("rd_valid", 32'(bus.inst_valid), 32'd0);
    tick();
    check("rd1_mem_req", 32'(bus.mem_req), 32'd1);
    check("rd1_valid", 32'(bus.inst_valid), 32'd0);
    tick();
    check("rd2_mem_addr", 32'(bus.mem_addr), 32'h0041);
    check("rd2_valid", 32'(bus.inst_valid), 32'd0);
    tick();
    check("i3_inst", 32'(bus.inst), 32'h8123);
    check("i3_pc", 32'(bus.inst_pc), 32'h0040);
    check("i3_next_pc", 32'(bus.next_pc), 32'h0042);
    check("i3_len", 32'(bus.inst_len), 32'd2);

    // Random ack delays over a short program
    rand_mode      = 1'b1;
    bus.inst_ready = 1'b1;
    tick();
    foreach (stream[n]) begin
      for (int k = 0; k < 40 && !bus.inst_valid; k++) tick();
      check("rnd_valid", 32'(bus.inst_valid), 32'd1);
      check("rnd_inst", 32'(bus.inst), 32'(stream[n].inst));
      check("rnd_pc", 32'(bus.inst_pc), 32'(stream[n].pc));
      check("rnd_len", 32'(bus.inst_len), 32'(stream[n].len));
      check("rnd_next_pc", 32'(bus.next_pc), 32'(stream[n].pc + 16'(stream[n].len)));
      tick();
    end
    check("addr_stable", 32'(addr_unstable), 32'd0);

    // Wrap-around: 2-byte instruction at 16'hFFFF
    mem[16'hFFFF] = 8'hC0;
    mem[0]        = 8'h10;
    rst2 = 1'b0;
    tick();
    check("w_mem_addr", 32'(bus2.mem_addr), 32'hFFFF);
    tick();
    check("w_lo_addr", 32'(bus2.mem_addr), 32'h0000);
    tick();
    check("w_valid", 32'(bus2.inst_valid), 32'd1);
    check("w_inst", 32'(bus2.inst), 32'hC010);
    check("w_pc", 32'(bus2.inst_pc), 32'hFFFF);
    check("w_next_pc", 32'(bus2.next_pc), 32'h0001);
    check("w_len", 32'(bus2.inst_len), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decoder.
- Pulls instruction bytes from the byte-wide memory bus and assembles them into a 16-bit instruction word: opcode byte in inst[15:8], argument byte in inst[7:0].
- Uses opcode bit 7 to decide between a 1-byte (zero-arg) and a 2-byte (one-arg) instruction.
- Presents the word with a valid/ready handshake; inst_valid drives the decoder's en, and inst drives the decoder's inst.
- Accepts PC redirects from branch, call and return execution.

Parameters:
- RESET_PC, 16'h0000, address of the first fetch after reset.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_req  output  1  byte read request; held high until acked.
- mem_addr  output  16  byte address; stable while mem_req is high.
- mem_ack  input  1  one-cycle pulse; mem_rdata is valid in the same cycle.
- mem_rdata  input  8  read data byte.
- inst  output  16  assembled instruction word.
- inst_valid  output  1  inst, inst_pc, inst_len and next_pc are valid.
- inst_ready  input  1  consumer accepts the instruction this cycle.
- inst_pc  output  16  address of the instruction's first byte.
- inst_len  output  2  1 or 2; equals the decoder's bytes output.
- next_pc  output  16  inst_pc + inst_len, mod 2^16; used as the call return address.
- redirect  input  1  one-cycle pulse: restart fetch at redirect_pc.
- redirect_pc  input  16  new fetch address.

Behaviour:
- Reset (rst=1 at an edge):
  - state=FETCH_HI, pc=RESET_PC.
  - mem_req=0, inst=0, inst_valid=0, inst_pc=0, inst_len=0, next_pc=0.
  - mem_req rises on the first cycle after rst is deasserted.
  - Reset mid-operation abandons any fetch in progress; the bus must tolerate req withdrawal.
- States:
  - FETCH_HI: mem_req=1, mem_addr=pc.
    - On mem_ack: latch mem_rdata into inst[15:8]; inst_pc<=pc; pc<=pc+1.
    - If mem_rdata[7]=0: inst[7:0]<=8'h00, inst_len<=1, go to HOLD.
    - Otherwise go to FETCH_LO.
  - FETCH_LO: mem_req=1, mem_addr=pc.
    - On mem_ack: inst[7:0]<=mem_rdata; pc<=pc+1; inst_len<=2; go to HOLD.
  - HOLD: mem_req=0, inst_valid=1; all outputs held stable.
    - On inst_ready: go to FETCH_HI; inst_valid drops the next cycle.
- Ordering:
  - Memory never acks when mem_req=0; any such ack is ignored.
  - No prefetch. Exactly one instruction is in flight.
- Latency, with mem_ack in the same cycle as mem_req:
  - 1-byte instruction: inst_valid rises 1 cycle after the FETCH_HI ack.
  - 2-byte instruction: inst_valid rises 1 cycle after the FETCH_LO ack.
  - Back-to-back 1-byte throughput is one instruction per 2 cycles.
- PC arithmetic is 16-bit with wrap-around:
  - pc 16'hFFFF increments to 16'h0000.
  - A 2-byte instruction at 16'hFFFF takes its low byte from 16'h0000, with next_pc=16'h0001.
- Redirect has the highest priority, in any state:
  - Next state: pc<=redirect_pc, state<=FETCH_HI, inst_valid<=0, mem_req<=0 for that one cycle.
  - A mem_ack in the same cycle as redirect is discarded.
  - A simultaneous inst_ready has no further effect.
  - Fetch restarts at redirect_pc on the cycle after the redirect.
- Simultaneous rst and redirect: rst wins.
- inst_len=0 whenever inst_valid=0 after reset; after the first instruction, stale values are permitted while invalid.

Decomposition:
- Shared package cpu_pkg holds:
  - the fetch_state_t enum {FETCH_HI, FETCH_LO, HOLD};
  - constant OPC_ONE_ARG_BIT=7, the opcode-byte bit selecting a 2-byte instruction;
  - constant DEFAULT_RESET_PC=16'h0000.
- The decoder reuses the same bit constant.
- No sub-module. The PC incrementer and the byte assembly are inline.

Test Plan:
- Reset, then memory acks every request: mem[0]=8'h01 → inst=16'h0100, inst_len=1, inst_pc=0, next_pc=1, inst_valid 2 cycles after rst falls.
- mem[0..1]=8'h88,8'h05 with inst_ready tied high → inst=16'h8805, inst_len=2, next_pc=2; next fetch at address 2.
- Hold inst_ready low 5 cycles in HOLD → inst, inst_pc and inst_valid stable; mem_req=0 throughout.
- redirect=1 with redirect_pc=16'h0040 in FETCH_LO, with mem_ack in the same cycle → acked byte dropped; next mem_addr=16'h0040; inst_valid stays 0 until the new instruction is assembled.
- RESET_PC=16'hFFFF, mem[FFFF]=8'hC0, mem[0000]=8'h10 → inst=16'hC010, inst_pc=16'hFFFF, next_pc=16'h0001.
- Random ack delays of 0–7 cycles → mem_addr stable while mem_req is high; the instruction stream matches the memory image.
